multdiv_sequencer: RTL

MULTDIV_SEQUENCER -- requirements
Module: multdiv_sequencer

---
 rtl/multdiv_pkg.sv | 21 ++
 rtl/multdiv_counter.sv | 42 ++++
 rtl/multdiv_sequencer.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/multdiv_pkg.sv
// Shared definitions for the multiply/divide sequencer and the pipeline stall control.
package multdiv_pkg;

  localparam int ITERS = 32;
  localparam int CNT_W = 6;

  localparam logic [4:0] ALUOP_MULT = 5'b00110;
  localparam logic [4:0] ALUOP_DIV  = 5'b00111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic is_busy_state(input state_e s);
    return (s == MULT) || (s == DIV);
  endfunction

endpackage

// File: rtl/multdiv_counter.sv
// Iteration counter for the multiply/divide sequencer: counts 0..ITERS and saturates.
module multdiv_counter #(
  parameter int ITERS = multdiv_pkg::ITERS
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  import multdiv_pkg::CNT_W;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(ITERS - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(ITERS);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Saturating at FULL keeps the count from wrapping if enable lingers.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != FULL)) begin
      count_d = count_q + ONE;
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign terminal = (count_q == LAST);

endmodule

// File: rtl/multdiv_sequencer.sv
// Iterative signed multiplier (radix-2 Booth) and restoring divider with a fixed
// ITERS-cycle latency and a one-cycle ready pulse for the pipeline stall logic.
module multdiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int ITERS = multdiv_pkg::ITERS
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);
  import multdiv_pkg::*;

  localparam int AW = 2 * WIDTH + 1;
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      return ~v + ONE_W;
    end else begin
      return v;
    end
  endfunction

  state_e state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic             qm1_q, qm1_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             exc_q, exc_d;

  logic             start_s;
  logic             cnt_en_s;
  logic             last_s;
  logic             busy_s;
  logic             rdy_s;
  logic [WIDTH:0]   p_s, a_ext_s, p_sum_s;
  logic [AW-1:0]    booth_acc_s;
  logic [2*WIDTH-1:0] prod_s;
  logic             mult_ovf_s;
  logic [WIDTH-1:0] bmag_s;
  logic [WIDTH:0]   r_sh_s, diff_s;
  logic [AW-1:0]    div_acc_s;
  logic [WIDTH-1:0] quot_s, quot_signed_s;

  assign start_s  = ctrl_MULT | ctrl_DIV;
  assign cnt_en_s = is_busy_state(state_q) && !start_s;

  multdiv_counter #(
    .ITERS(ITERS)
  ) u_counter (
    .clock   (clock),
    .reset   (reset),
    .clear   (start_s),
    .enable  (cnt_en_s),
    .terminal(last_s)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A start pulse restarts from any state, multiply taking precedence.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: begin
        if (ctrl_MULT) begin
          state_d = MULT;
        end else if (ctrl_DIV) begin
          state_d = DIV;
        end else begin
          state_d = IDLE;
        end
      end
      MULT, DIV: begin
        if (ctrl_MULT) begin
          state_d = MULT;
        end else if (ctrl_DIV) begin
          state_d = DIV;
        end else if (last_s) begin
          state_d = DONE;
        end else begin
          state_d = state_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_s = 1'b0;
    rdy_s  = 1'b0;
    case (state_q)
      MULT, DIV: busy_s = 1'b1;
      DONE:      rdy_s  = 1'b1;
      default: begin
        busy_s = 1'b0;
        rdy_s  = 1'b0;
      end
    endcase
  end

  // Booth step: the upper field is WIDTH+1 bits so the most negative multiplicand cannot overflow it.
  always_comb begin
    p_s     = acc_q[AW-1:WIDTH];
    a_ext_s = {a_q[WIDTH-1], a_q};
    case ({acc_q[0], qm1_q})
      2'b01:   p_sum_s = p_s + a_ext_s;
      2'b10:   p_sum_s = p_s - a_ext_s;
      default: p_sum_s = p_s;
    endcase
    booth_acc_s = {p_sum_s[WIDTH], p_sum_s, acc_q[WIDTH-1:1]};
    prod_s      = booth_acc_s[2*WIDTH-1:0];
    mult_ovf_s  = (prod_s[2*WIDTH-1:WIDTH] != {WIDTH{prod_s[WIDTH-1]}});
  end

  // Restoring divide step on magnitudes: remainder in the upper field, dividend/quotient below.
  always_comb begin
    bmag_s = magnitude(b_q);
    r_sh_s = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    diff_s = r_sh_s - {1'b0, bmag_s};
    if (!diff_s[WIDTH]) begin
      div_acc_s = {diff_s, acc_q[WIDTH-2:0], 1'b1};
    end else begin
      div_acc_s = {r_sh_s, acc_q[WIDTH-2:0], 1'b0};
    end
    quot_s = div_acc_s[WIDTH-1:0];
    if (a_q[WIDTH-1] ^ b_q[WIDTH-1]) begin
      quot_signed_s = ~quot_s + ONE_W;
    end else begin
      quot_signed_s = quot_s;
    end
  end

  always_comb begin
    acc_d    = acc_q;
    qm1_d    = qm1_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    exc_d    = exc_q;
    if (start_s) begin
      a_d   = data_operandA;
      b_d   = data_operandB;
      qm1_d = 1'b0;
      if (ctrl_MULT) begin
        acc_d = {{(WIDTH+1){1'b0}}, data_operandB};
      end else begin
        acc_d = {{(WIDTH+1){1'b0}}, magnitude(data_operandA)};
      end
    end else if (state_q == MULT) begin
      acc_d = booth_acc_s;
      qm1_d = acc_q[0];
      if (last_s) begin
        result_d = prod_s[WIDTH-1:0];
        exc_d    = mult_ovf_s;
      end else begin
        result_d = result_q;
        exc_d    = exc_q;
      end
    end else if (state_q == DIV) begin
      acc_d = div_acc_s;
      if (!last_s) begin
        result_d = result_q;
        exc_d    = exc_q;
      end else if (b_q == '0) begin
        result_d = '0;
        exc_d    = 1'b1;
      end else if ((a_q == MIN_NEG) && (b_q == '1)) begin
        result_d = MIN_NEG;
        exc_d    = 1'b1;
      end else begin
        result_d = quot_signed_s;
        exc_d    = 1'b0;
      end
    end else begin
      acc_d = acc_q;
      qm1_d = qm1_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q    <= '0;
      qm1_q    <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      exc_q    <= 1'b0;
    end else begin
      acc_q    <= acc_d;
      qm1_q    <= qm1_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      exc_q    <= exc_d;
    end
  end

  assign data_result    = result_q;
  assign data_exception = exc_q;
  assign data_resultRDY = rdy_s;
  assign busy           = busy_s;

endmodule
